// File: rtl/edge_stim_pkg.sv
// Shared types, default timing constants and the a_o window helper for edge_stim_gen.
package edge_stim_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int unsigned DEF_CNT_W    = 8;
    localparam int unsigned DEF_C_PERIOD = 5;
    localparam int unsigned DEF_B_PERIOD = 7;
    localparam int unsigned DEF_A_START  = 22;
    localparam int unsigned DEF_A_WIDTH  = 5;
    localparam int unsigned DEF_RUN_LEN  = 100;

    // Half-open window [start, start+width); width 0 yields an empty window.
    function automatic logic in_window(input int unsigned k,
                                       input int unsigned start,
                                       input int unsigned width);
        return (k >= start) && (k < start + width);
    endfunction

endpackage

// File: rtl/toggle_div.sv
// Free-running toggle: out inverts once every PERIOD enabled cycles, via a reloading down-counter.
module toggle_div #(
    parameter int unsigned PERIOD = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic out
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (clr) begin
            cnt_d = RELOAD;
            out_d = 1'b0;
        end else if (en) begin
            if (cnt_q == '0) begin
                cnt_d = RELOAD;
                out_d = ~out_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/edge_stim_gen.sv
// Deterministic level-pulse / toggle / run-done stimulus source for event-sensitivity diagnostics.
module edge_stim_gen
    import edge_stim_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned C_PERIOD = DEF_C_PERIOD,
    parameter int unsigned B_PERIOD = DEF_B_PERIOD,
    parameter int unsigned A_START  = DEF_A_START,
    parameter int unsigned A_WIDTH  = DEF_A_WIDTH,
    parameter int unsigned RUN_LEN  = DEF_RUN_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             stop_i,
    output logic             a_o,
    output logic             b_o,
    output logic             c_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cycle_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic             a_q, a_d;
    logic             last_cycle;
    logic             enter_run;
    logic             advance;
    logic             clr_wave;

    assign last_cycle = (k_q == CNT_W'(RUN_LEN - 1));
    assign enter_run  = (state_d == RUN) && (state_q != RUN);
    assign advance    = (state_d == RUN) && (state_q == RUN);
    assign clr_wave   = enter_run || (state_d == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // stop_i outranks everything; start_i only matters outside RUN.
    always_comb begin
        state_d = state_q;
        if (stop_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i) state_d = RUN;
                RUN:     if (last_cycle) state_d = DONE;
                DONE:    if (start_i) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o = (state_q == RUN);
        done_o = (state_q == DONE);
    end

    // a_o is computed from the next k so it is registered alongside cycle_o.
    always_comb begin
        k_d = k_q;
        if (state_d == IDLE || enter_run) begin
            k_d = '0;
        end else if (advance) begin
            k_d = k_q + 1'b1;
        end
        a_d = (state_d == RUN) && in_window(int'(k_d), A_START, A_WIDTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= '0;
            a_q <= 1'b0;
        end else begin
            k_q <= k_d;
            a_q <= a_d;
        end
    end

    toggle_div #(.PERIOD(B_PERIOD)) u_div_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_wave),
        .en    (advance),
        .out   (b_o)
    );

    toggle_div #(.PERIOD(C_PERIOD)) u_div_c (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_wave),
        .en    (advance),
        .out   (c_o)
    );

    assign a_o     = a_q;
    assign cycle_o = k_q;

endmodule

// File: tb/tb_edge_stim_gen.sv
// Scoreboard bench: a default instance and a short instance (C_PERIOD=1, A_WIDTH=0, RUN_LEN=10) share stimulus.
module tb_edge_stim_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_i = 1'b0;
    logic       stop_i = 1'b0;

    logic       a0, b0, c0, busy0, done0;
    logic [7:0] cyc0;
    logic       a1, b1, c1, busy1, done1;
    logic [7:0] cyc1;

    int unsigned checks = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    edge_stim_gen #(
        .CNT_W(8), .C_PERIOD(5), .B_PERIOD(7), .A_START(22), .A_WIDTH(5), .RUN_LEN(100)
    ) u_dut_def (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
        .a_o(a0), .b_o(b0), .c_o(c0), .busy_o(busy0), .done_o(done0), .cycle_o(cyc0)
    );

    edge_stim_gen #(
        .CNT_W(8), .C_PERIOD(1), .B_PERIOD(7), .A_START(22), .A_WIDTH(0), .RUN_LEN(10)
    ) u_dut_short (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
        .a_o(a1), .b_o(b1), .c_o(c1), .busy_o(busy1), .done_o(done1), .cycle_o(cyc1)
    );

    // Reference parameters per instance: index 0 default, 1 short.
    int cp [2] = '{5, 1};
    int bp [2] = '{7, 7};
    int as_ [2] = '{22, 22};
    int aw [2] = '{5, 0};
    int rl [2] = '{100, 10};

    // Model state: 0 idle, 1 run, 2 done.
    int m_st [2] = '{0, 0};
    int m_k  [2] = '{0, 0};

    logic [25:0] sb_q [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected {a,b,c,busy,done,cycle} derived from closed-form k arithmetic.
    function automatic logic [12:0] model_out(input int i);
        int   kk;
        logic a, b, c;
        if (m_st[i] == 0) return '0;
        kk = (m_st[i] == 1) ? m_k[i] : rl[i] - 1;
        a  = (m_st[i] == 1) && (kk >= as_[i]) && (kk < as_[i] + aw[i]);
        b  = ((kk / bp[i]) % 2) == 1;
        c  = ((kk / cp[i]) % 2) == 1;
        return {a, b, c, (m_st[i] == 1), (m_st[i] == 2), 8'(kk)};
    endfunction

    task automatic model_advance(input logic s, input logic p);
        for (int i = 0; i < 2; i++) begin
            if (p) begin
                m_st[i] = 0;
                m_k[i]  = 0;
            end else begin
                case (m_st[i])
                    0: if (s) begin m_st[i] = 1; m_k[i] = 0; end
                    1: if (m_k[i] == rl[i] - 1) m_st[i] = 2; else m_k[i] = m_k[i] + 1;
                    default: if (s) begin m_st[i] = 1; m_k[i] = 0; end
                endcase
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0;
            m_k[i]  = 0;
        end
    endtask

    task automatic push_expected();
        sb_q.push_back({model_out(0), model_out(1)});
    endtask

    task automatic compare_pop(input string tag);
        logic [25:0] exp;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        exp = sb_q.pop_front();
        check_eq({tag, "_def"},   {19'd0, a0, b0, c0, busy0, done0, cyc0}, {19'd0, exp[25:13]});
        check_eq({tag, "_short"}, {19'd0, a1, b1, c1, busy1, done1, cyc1}, {19'd0, exp[12:0]});
    endtask

    task automatic step(input logic s, input logic p, input string tag);
        start_i = s;
        stop_i  = p;
        model_advance(s, p);
        push_expected();
        @(posedge clk);
        #1;
        compare_pop(tag);
    endtask

    initial begin
        // Asynchronous reset at start, checked before any clock edge arrives.
        #2 rst_n = 1'b0;
        model_reset();
        push_expected();
        #1 compare_pop("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int j = 0; j < 3; j++) step(1'b0, 1'b0, "idle0");

        // Defaults run; a second start during RUN at k=40 (restarts the short instance from DONE).
        step(1'b1, 1'b0, "run1");
        for (int j = 1; j < 110; j++) step(j == 41, 1'b0, "run1");

        // Restart from DONE.
        step(1'b1, 1'b0, "restart");
        for (int j = 1; j < 105; j++) step(1'b0, 1'b0, "restart");

        // stop_i with start_i mid-pulse at k=24, then a fresh start.
        step(1'b1, 1'b0, "pre_stop");
        for (int j = 1; j <= 24; j++) step(1'b0, 1'b0, "pre_stop");
        step(1'b1, 1'b1, "stop");
        for (int j = 0; j < 3; j++) step(1'b0, 1'b0, "stopped");
        step(1'b1, 1'b0, "after_stop");
        for (int j = 1; j <= 50; j++) step(1'b0, 1'b0, "after_stop");

        // Asynchronous reset between edges at k=50.
        #2 rst_n = 1'b0;
        model_reset();
        push_expected();
        #1 compare_pop("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int j = 0; j < 5; j++) step(1'b0, 1'b0, "post_rst_idle");
        step(1'b1, 1'b0, "post_rst_run");
        for (int j = 1; j < 15; j++) step(1'b0, 1'b0, "post_rst_run");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
